// File: rtl/riscv_mem_stage.sv
// riscv_mem_pkg / riscv_mem_stage
//
// Purpose:
//   In-order MEM stage of a RISC-V pipeline. It takes the execute-stage result,
//   issues at most one load/store transaction at a time on a valid/ready request
//   channel, and aligns and extends returned load data. The result goes to a
//   writeback output register that holds until writeback consumes it.
//   Misaligned accesses and bus errors are reported as a one-cycle exception
//   pulse that carries a cause and the faulting address.
//
// Ports:
//   clk_i, rst_ni       core clock, asynchronous active-low reset
//   flush_i             kills the held or in-flight instruction
//   ex_data_i           execute result (.valid qualifies)
//   ex_ready_o          stage accepts ex_data_i this cycle
//   mem_req_valid_o     request valid
//   mem_req_ready_i     request accepted
//   mem_req_o           request payload
//   mem_rsp_valid_i     response valid (always accepted)
//   mem_rsp_i           response payload
//   wb_data_o           writeback payload (.valid qualifies)
//   wb_ready_i          writeback consumes wb_data_o
//   exc_valid_o         one-cycle exception pulse
//   exc_cause_o         01 load misalign, 10 store misalign, 11 access fault
//   exc_tval_o          faulting address

package riscv_mem_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2_data;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_size;
    logic [3:0]      mem_strb;
  } execute_data_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [2:0]      size;
    logic            write;
    logic [XLEN-1:0] wdata;
    logic [3:0]      strb;
    logic [3:0]      id;
    logic [2:0]      prot;
    logic            cacheable;
  } memory_req_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            error;
    logic [3:0]      id;
  } memory_rsp_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mem_data;
  } memory_data_t;
endpackage

module riscv_mem_stage
  import riscv_mem_pkg::*;
#(
  parameter logic [3:0] REQ_ID   = 4'h1,
  parameter logic [2:0] REQ_PROT = 3'b000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  execute_data_t     ex_data_i,
  output logic              ex_ready_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output memory_req_t       mem_req_o,
  input  logic              mem_rsp_valid_i,
  input  memory_rsp_t       mem_rsp_i,
  output memory_data_t      wb_data_o,
  input  logic              wb_ready_i,
  output logic              exc_valid_o,
  output logic [1:0]        exc_cause_o,
  output logic [XLEN-1:0]   exc_tval_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DRAIN} state_e;

  state_e          state_q, state_d;
  execute_data_t   insn_q, insn_d;
  memory_req_t     req_q, req_d;
  memory_data_t    wb_q, wb_d;
  logic            excValid_q, excValid_d;
  logic [1:0]      excCause_q, excCause_d;
  logic [XLEN-1:0] excTval_q, excTval_d;

  logic            exReady;
  logic            accept;
  logic            isMem;
  logic            misalign;
  logic            rspHit;
  logic [XLEN-1:0] rspShifted;
  logic [XLEN-1:0] loadData;

  assign exReady  = (state_q == IDLE) && (!wb_q.valid || wb_ready_i) && !flush_i;
  assign accept   = ex_data_i.valid && exReady;
  assign isMem    = ex_data_i.mem_read || ex_data_i.mem_write;
  assign rspHit   = mem_rsp_valid_i && (mem_rsp_i.id == REQ_ID);

  // Size encoding 11 is treated like a word for the alignment check.
  always_comb begin
    misalign = 1'b0;
    case (ex_data_i.mem_size[1:0])
      2'b01:   misalign = ex_data_i.alu_result[0];
      2'b10,
      2'b11:   misalign = (ex_data_i.alu_result[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  // Bring the addressed byte lane down to bit 0, then extend by load type.
  assign rspShifted = mem_rsp_i.data >> {insn_q.alu_result[1:0], 3'b000};

  always_comb begin
    loadData = rspShifted;
    case (insn_q.mem_size)
      3'b000:  loadData = {{24{rspShifted[7]}}, rspShifted[7:0]};
      3'b001:  loadData = {{16{rspShifted[15]}}, rspShifted[15:0]};
      3'b100:  loadData = {24'b0, rspShifted[7:0]};
      3'b101:  loadData = {16'b0, rspShifted[15:0]};
      default: loadData = rspShifted;
    endcase
  end

  // Next-state and datapath. A flush always has the final say on the output
  // register and suppresses any exception raised in the same cycle.
  always_comb begin
    state_d    = state_q;
    insn_d     = insn_q;
    req_d      = req_q;
    wb_d       = wb_q;
    excValid_d = 1'b0;
    excCause_d = excCause_q;
    excTval_d  = excTval_q;

    if (wb_q.valid && wb_ready_i) wb_d.valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!isMem) begin
            wb_d.valid      = 1'b1;
            wb_d.pc         = ex_data_i.pc;
            wb_d.rd         = ex_data_i.rd;
            wb_d.rd_we      = ex_data_i.rd_we;
            wb_d.alu_result = ex_data_i.alu_result;
            wb_d.mem_data   = '0;
          end else if (misalign) begin
            excValid_d = 1'b1;
            excCause_d = ex_data_i.mem_write ? 2'b10 : 2'b01;
            excTval_d  = ex_data_i.alu_result;
          end else begin
            insn_d          = ex_data_i;
            req_d.addr      = ex_data_i.alu_result;
            req_d.size      = {1'b0, ex_data_i.mem_size[1:0]};
            req_d.write     = ex_data_i.mem_write;
            req_d.id        = REQ_ID;
            req_d.prot      = REQ_PROT;
            req_d.cacheable = 1'b1;
            case (ex_data_i.mem_size[1:0])
              2'b00: begin
                req_d.wdata = {4{ex_data_i.rs2_data[7:0]}};
                req_d.strb  = 4'b0001 << ex_data_i.alu_result[1:0];
              end
              2'b01: begin
                req_d.wdata = {2{ex_data_i.rs2_data[15:0]}};
                req_d.strb  = 4'b0011 << ex_data_i.alu_result[1:0];
              end
              default: begin
                req_d.wdata = ex_data_i.rs2_data;
                req_d.strb  = 4'hF;
              end
            endcase
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // A request handshaked in the flush cycle is already outstanding, so
        // its response still has to be drained.
        if (mem_req_ready_i) state_d = flush_i ? DRAIN : WAIT_RSP;
        else if (flush_i)    state_d = IDLE;
      end
      WAIT_RSP: begin
        if (flush_i) begin
          state_d = rspHit ? IDLE : DRAIN;
        end else if (rspHit) begin
          state_d = IDLE;
          if (mem_rsp_i.error) begin
            excValid_d = 1'b1;
            excCause_d = 2'b11;
            excTval_d  = insn_q.alu_result;
          end else begin
            wb_d.valid      = 1'b1;
            wb_d.pc         = insn_q.pc;
            wb_d.rd         = insn_q.rd;
            wb_d.rd_we      = insn_q.rd_we;
            wb_d.alu_result = insn_q.alu_result;
            wb_d.mem_data   = insn_q.mem_write ? '0 : loadData;
          end
        end
      end
      DRAIN: begin
        if (rspHit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) wb_d.valid = 1'b0;
  end

  // State and payload registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      insn_q     <= '0;
      req_q      <= '0;
      wb_q       <= '0;
      excValid_q <= 1'b0;
      excCause_q <= 2'b00;
      excTval_q  <= '0;
    end else begin
      state_q    <= state_d;
      insn_q     <= insn_d;
      req_q      <= req_d;
      wb_q       <= wb_d;
      excValid_q <= excValid_d;
      excCause_q <= excCause_d;
      excTval_q  <= excTval_d;
    end
  end

  assign ex_ready_o      = exReady;
  assign mem_req_valid_o = (state_q == REQ);
  assign mem_req_o       = req_q;
  assign wb_data_o       = wb_q;
  assign exc_valid_o     = excValid_q;
  assign exc_cause_o     = excCause_q;
  assign exc_tval_o      = excTval_q;

endmodule

// File: tb/tb_riscv_mem_stage.sv
// tb_riscv_mem_stage
//
// Purpose:
//   Directed self-checking bench for riscv_mem_stage. Each scenario task drives
//   its stimulus and compares outputs against hand-computed expected values.
//   Inputs are driven 2 ns after the rising edge and outputs are sampled there.

module tb_riscv_mem_stage;
  import riscv_mem_pkg::*;

  logic          clk_i;
  logic          rst_ni;
  logic          flush_i;
  execute_data_t ex_data_i;
  logic          ex_ready_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  memory_req_t   mem_req_o;
  logic          mem_rsp_valid_i;
  memory_rsp_t   mem_rsp_i;
  memory_data_t  wb_data_o;
  logic          wb_ready_i;
  logic          exc_valid_o;
  logic [1:0]    exc_cause_o;
  logic [31:0]   exc_tval_o;

  int nChecks = 0;
  int nFails  = 0;

  riscv_mem_stage dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .ex_data_i       (ex_data_i),
    .ex_ready_o      (ex_ready_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_o       (mem_req_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_i       (mem_rsp_i),
    .wb_data_o       (wb_data_o),
    .wb_ready_i      (wb_ready_i),
    .exc_valid_o     (exc_valid_o),
    .exc_cause_o     (exc_cause_o),
    .exc_tval_o      (exc_tval_o)
  );

  // 10 ns core clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  function automatic execute_data_t mkEx(input logic [31:0] pc, input logic [31:0] alu,
                                         input logic [31:0] rs2, input logic [4:0] rd,
                                         input logic rdWe, input logic rdOp,
                                         input logic wrOp, input logic [2:0] size);
    execute_data_t e;
    e            = '0;
    e.valid      = 1'b1;
    e.pc         = pc;
    e.alu_result = alu;
    e.rs2_data   = rs2;
    e.rd         = rd;
    e.rd_we      = rdWe;
    e.mem_read   = rdOp;
    e.mem_write  = wrOp;
    e.mem_size   = size;
    e.mem_strb   = 4'hA;
    return e;
  endfunction

  task automatic test_reset();
    rst_ni          = 1'b0;
    flush_i         = 1'b0;
    ex_data_i       = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_i       = '0;
    wb_ready_i      = 1'b1;
    repeat (2) cyc();
    nChecks++;
    if (wb_data_o !== '0) begin
      nFails++; $display("[TB] FAIL reset_wb got=%h exp=0", wb_data_o);
    end
    nChecks++;
    if (mem_req_valid_o !== 1'b0 || mem_req_o !== '0) begin
      nFails++; $display("[TB] FAIL reset_req got valid=%b req=%h exp=0", mem_req_valid_o, mem_req_o);
    end
    nChecks++;
    if ({exc_valid_o, exc_cause_o, exc_tval_o} !== 35'b0) begin
      nFails++; $display("[TB] FAIL reset_exc got=%b/%b/%h exp=0", exc_valid_o, exc_cause_o, exc_tval_o);
    end
    rst_ni = 1'b1;
    cyc();
    nChecks++;
    if (ex_ready_o !== 1'b1) begin
      nFails++; $display("[TB] FAIL reset_ready got=%b exp=1", ex_ready_o);
    end
  endtask

  task automatic test_alu_passthrough();
    logic [31:0] aluVals [3];
    aluVals = '{32'hDEAD_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    wb_ready_i = 1'b1;
    ex_data_i  = mkEx(32'h100, aluVals[0], 32'h5555_5555, 5'd1, 1'b1, 1'b0, 1'b0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i < 2)
        ex_data_i = mkEx(32'h100 + 32'(4 * (i + 1)), aluVals[i + 1], 32'h5555_5555,
                         5'(i + 2), 1'b1, 1'b0, 1'b0, 3'b010);
      else
        ex_data_i = '0;
      nChecks++;
      if (wb_data_o.valid !== 1'b1 || wb_data_o.alu_result !== aluVals[i] ||
          wb_data_o.pc !== 32'h100 + 32'(4 * i) || wb_data_o.rd !== 5'(i + 1) ||
          wb_data_o.mem_data !== 32'h0) begin
        nFails++;
        $display("[TB] FAIL alu_op%0d got v=%b alu=%h pc=%h rd=%0d md=%h exp v=1 alu=%h pc=%h rd=%0d md=0",
                 i, wb_data_o.valid, wb_data_o.alu_result, wb_data_o.pc, wb_data_o.rd,
                 wb_data_o.mem_data, aluVals[i], 32'h100 + 32'(4 * i), i + 1);
      end
    end
    cyc();
    nChecks++;
    if (wb_data_o.valid !== 1'b0) begin
      nFails++; $display("[TB] FAIL alu_drain got=%b exp=0", wb_data_o.valid);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  sizes [2];
    logic [31:0] expData [2];
    sizes   = '{3'b000, 3'b100};
    expData = '{32'hFFFF_FF80, 32'h0000_0080};
    wb_ready_i      = 1'b1;
    mem_req_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ex_data_i = mkEx(32'h200, 32'h1003, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, sizes[i]);
      cyc();
      ex_data_i = '0;
      nChecks++;
      if (mem_req_valid_o !== 1'b1 || mem_req_o.addr !== 32'h1003 || mem_req_o.write !== 1'b0 ||
          mem_req_o.size !== 3'b000 || mem_req_o.strb !== 4'b1000 || mem_req_o.id !== 4'h1 ||
          mem_req_o.prot !== 3'b000 || mem_req_o.cacheable !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL load%0d_req got v=%b req=%h exp v=1 addr=1003 size=0 strb=8 id=1 cacheable=1",
                 i, mem_req_valid_o, mem_req_o);
      end
      cyc();
      mem_rsp_valid_i = 1'b1;
      mem_rsp_i       = '{data: 32'h80FF_FF00, error: 1'b0, id: 4'h1};
      nChecks++;
      if (wb_data_o.valid !== 1'b0 || mem_req_valid_o !== 1'b0) begin
        nFails++; $display("[TB] FAIL load%0d_t2 got wbv=%b reqv=%b exp 0/0", i, wb_data_o.valid, mem_req_valid_o);
      end
      cyc();
      mem_rsp_valid_i = 1'b0;
      #1;
      nChecks++;
      if (wb_data_o.valid !== 1'b1 || wb_data_o.mem_data !== expData[i] ||
          wb_data_o.rd !== 5'd7 || ex_ready_o !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL load%0d_result got v=%b data=%h rd=%0d rdy=%b exp v=1 data=%h rd=7 rdy=1",
                 i, wb_data_o.valid, wb_data_o.mem_data, wb_data_o.rd, ex_ready_o, expData[i]);
      end
      cyc();
    end
    mem_req_ready_i = 1'b0;
  endtask

  task automatic test_store_stall();
    wb_ready_i      = 1'b1;
    mem_req_ready_i = 1'b0;
    ex_data_i = mkEx(32'h300, 32'h2002, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001);
    cyc();
    ex_data_i = '0;
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (mem_req_valid_o !== 1'b1 || mem_req_o.addr !== 32'h2002 || mem_req_o.wdata !== 32'hBEEF_BEEF ||
          mem_req_o.strb !== 4'b1100 || mem_req_o.write !== 1'b1 || mem_req_o.size !== 3'b001) begin
        nFails++;
        $display("[TB] FAIL store_stall%0d got v=%b req=%h exp v=1 addr=2002 wdata=beefbeef strb=c write=1 size=1",
                 i, mem_req_valid_o, mem_req_o);
      end
      if (i == 2) mem_req_ready_i = 1'b1;
      cyc();
    end
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_i       = '{data: 32'hCAFE_F00D, error: 1'b0, id: 4'h1};
    nChecks++;
    if (mem_req_valid_o !== 1'b0) begin
      nFails++; $display("[TB] FAIL store_handshake got=%b exp=0", mem_req_valid_o);
    end
    cyc();
    mem_rsp_valid_i = 1'b0;
    nChecks++;
    if (wb_data_o.valid !== 1'b1 || wb_data_o.mem_data !== 32'h0 || wb_data_o.alu_result !== 32'h2002) begin
      nFails++;
      $display("[TB] FAIL store_result got v=%b md=%h alu=%h exp v=1 md=0 alu=2002",
               wb_data_o.valid, wb_data_o.mem_data, wb_data_o.alu_result);
    end
    cyc();
  endtask

  task automatic test_misalign();
    logic        wrOps [2];
    logic [1:0]  expCause [2];
    wrOps    = '{1'b0, 1'b1};
    expCause = '{2'b01, 2'b10};
    wb_ready_i      = 1'b1;
    mem_req_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ex_data_i = mkEx(32'h400, 32'h3001, 32'h1234_5678, 5'd3, 1'b1, !wrOps[i], wrOps[i], 3'b010);
      cyc();
      ex_data_i = '0;
      nChecks++;
      if (mem_req_valid_o !== 1'b0 || exc_valid_o !== 1'b1 || exc_cause_o !== expCause[i] ||
          exc_tval_o !== 32'h3001 || wb_data_o.valid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL misalign%0d got reqv=%b exc=%b cause=%b tval=%h wbv=%b exp 0/1/%b/3001/0",
                 i, mem_req_valid_o, exc_valid_o, exc_cause_o, exc_tval_o, wb_data_o.valid, expCause[i]);
      end
      cyc();
      nChecks++;
      if (exc_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
        nFails++; $display("[TB] FAIL misalign%0d_pulse got exc=%b reqv=%b exp 0/0", i, exc_valid_o, mem_req_valid_o);
      end
    end
    mem_req_ready_i = 1'b0;
  endtask

  task automatic test_error_and_stray();
    wb_ready_i      = 1'b1;
    mem_req_ready_i = 1'b1;
    ex_data_i = mkEx(32'h500, 32'h4000, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010);
    cyc();
    ex_data_i = '0;
    cyc();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_i       = '{data: 32'h1111_2222, error: 1'b0, id: 4'h7};
    cyc();
    mem_rsp_i       = '{data: 32'h0, error: 1'b1, id: 4'h1};
    #1;
    nChecks++;
    if (wb_data_o.valid !== 1'b0 || exc_valid_o !== 1'b0 || ex_ready_o !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL stray_rsp got wbv=%b exc=%b rdy=%b exp 0/0/0", wb_data_o.valid, exc_valid_o, ex_ready_o);
    end
    cyc();
    mem_rsp_valid_i = 1'b0;
    #1;
    nChecks++;
    if (exc_valid_o !== 1'b1 || exc_cause_o !== 2'b11 || exc_tval_o !== 32'h4000 ||
        wb_data_o.valid !== 1'b0 || ex_ready_o !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL rsp_error got exc=%b cause=%b tval=%h wbv=%b rdy=%b exp 1/11/4000/0/1",
               exc_valid_o, exc_cause_o, exc_tval_o, wb_data_o.valid, ex_ready_o);
    end
    cyc();
  endtask

  task automatic test_flush();
    wb_ready_i      = 1'b1;
    mem_req_ready_i = 1'b1;
    ex_data_i = mkEx(32'h600, 32'h5004, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010);
    cyc();
    ex_data_i = '0;
    cyc();
    mem_req_ready_i = 1'b0;
    flush_i = 1'b1;
    #1;
    nChecks++;
    if (ex_ready_o !== 1'b0) begin
      nFails++; $display("[TB] FAIL flush_ready got=%b exp=0", ex_ready_o);
    end
    cyc();
    flush_i = 1'b0;
    #1;
    nChecks++;
    if (ex_ready_o !== 1'b0) begin
      nFails++; $display("[TB] FAIL drain_ready got=%b exp=0", ex_ready_o);
    end
    mem_rsp_valid_i = 1'b1;
    mem_rsp_i       = '{data: 32'h1234_5678, error: 1'b0, id: 4'h1};
    cyc();
    mem_rsp_valid_i = 1'b0;
    #1;
    nChecks++;
    if (wb_data_o.valid !== 1'b0 || exc_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL drain_discard got wbv=%b exc=%b rdy=%b exp 0/0/1", wb_data_o.valid, exc_valid_o, ex_ready_o);
    end

    wb_ready_i = 1'b0;
    ex_data_i  = mkEx(32'h700, 32'hA5A5_0F0F, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 3'b010);
    cyc();
    ex_data_i = mkEx(32'h704, 32'h0BAD_0BAD, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      #1;
      nChecks++;
      if (wb_data_o.valid !== 1'b1 || wb_data_o.alu_result !== 32'hA5A5_0F0F || ex_ready_o !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL hold%0d got v=%b alu=%h rdy=%b exp 1/a5a50f0f/0",
                 i, wb_data_o.valid, wb_data_o.alu_result, ex_ready_o);
      end
      cyc();
    end
    ex_data_i = '0;
    flush_i   = 1'b1;
    cyc();
    flush_i   = 1'b0;
    nChecks++;
    if (wb_data_o.valid !== 1'b0) begin
      nFails++; $display("[TB] FAIL flush_clear got=%b exp=0", wb_data_o.valid);
    end
    wb_ready_i = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load_extend();
    test_store_stall();
    test_misalign();
    test_error_and_stray();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
